// File: rtl/sram_like_arbiter_pkg.sv
// Shared owner encodings and SRAM-like size codes for the two-master arbiter.
// Latency: none, constants and types only.
// Backpressure: not applicable.
package sram_like_arbiter_pkg;

  // One bit identifies which master issued an outstanding transaction.
  typedef logic owner_t;

  localparam owner_t OWN_INST = 1'b0;
  localparam owner_t OWN_DATA = 1'b1;

  // SRAM-like transfer size codes carried on the *_size buses.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order record of which master owns each accepted-but-unanswered transaction.
// Latency: push visible at head one cycle later; head/empty/full are registered-state views.
// Backpressure: push is ignored when full and pop is ignored when empty.
module sram_like_arbiter_owner_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push_i,
  input  owner_t din_i,
  input  logic   pop_i,
  output logic   empty_o,
  output logic   full_o,
  output owner_t head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic [DEPTH-1:0] mem_q;
  logic           do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~full_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // Occupancy and pointers clear immediately on reset, discarding stale owners.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the inst and data SRAM-like masters onto one slave port and routes responses back in order.
// Latency: zero cycles on request, accept and response paths (all combinational).
// Backpressure: slave addr_ok stall locks the grant; no new request while MAX_OUTSTANDING are in flight.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ROUND_ROBIN     = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  owner_t grant;
  logic   full, empty;
  owner_t head;
  logic   sel_req, push;

  logic   lock_q, lock_d;
  owner_t lock_owner_q, lock_owner_d;
  owner_t rr_last_q, rr_last_d;

  // Grant: a locked owner keeps the port; otherwise fixed priority or round-robin tie-break.
  always_comb begin
    grant = OWN_INST;
    if (lock_q) begin
      grant = lock_owner_q;
    end else if ((ROUND_ROBIN != 0) && inst_req && data_req) begin
      grant = (rr_last_q == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (data_req) begin
      grant = OWN_DATA;
    end
  end

  assign sel_req    = (grant == OWN_DATA) ? data_req   : inst_req;
  assign sram_req   = sel_req & ~full;
  assign sram_wr    = (grant == OWN_DATA) ? data_wr    : inst_wr;
  assign sram_size  = (grant == OWN_DATA) ? data_size  : inst_size;
  assign sram_wstrb = (grant == OWN_DATA) ? data_wstrb : inst_wstrb;
  assign sram_addr  = (grant == OWN_DATA) ? data_addr  : inst_addr;
  assign sram_wdata = (grant == OWN_DATA) ? data_wdata : inst_wdata;

  assign push         = sram_req & sram_addr_ok;
  assign inst_addr_ok = push & (grant == OWN_INST);
  assign data_addr_ok = push & (grant == OWN_DATA);

  // A stray data_ok with nothing outstanding reaches neither master.
  assign inst_data_ok = sram_data_ok & ~empty & (head == OWN_INST);
  assign data_data_ok = sram_data_ok & ~empty & (head == OWN_DATA);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

  // A stalled request locks the grant; acceptance or owner cancel (req drop) releases it.
  always_comb begin
    lock_d       = sram_req & ~sram_addr_ok;
    lock_owner_d = lock_d ? grant : lock_owner_q;
    rr_last_d    = push ? grant : rr_last_q;
  end

  // Lock and round-robin history; rr_last resets to data so inst wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_INST;
      rr_last_q    <= OWN_DATA;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      rr_last_q    <= rr_last_d;
    end
  end

  sram_like_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .din_i   (grant),
    .pop_i   (sram_data_ok),
    .empty_o (empty),
    .full_o  (full),
    .head_o  (head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter from shared stimulus and checks both against a queue model.
// Latency: checks every cycle at the falling edge, plus directed checks for the key scenarios.
// Backpressure: slave addr_ok/data_ok are driven directly by the bench.
module tb_sram_like_arbiter;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;

  // Index 0: fixed priority, index 1: round-robin.
  logic [1:0]       inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_req, sram_wr;
  logic [1:0][31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
  logic [1:0][1:0]  sram_size;
  logic [1:0][3:0]  sram_wstrb;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_like_arbiter #(
      .MAX_OUTSTANDING (MAXO),
      .ROUND_ROBIN     (g)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_wstrb   (inst_wstrb),
      .inst_addr    (inst_addr),
      .inst_wdata   (inst_wdata),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .sram_req     (sram_req[g]),
      .sram_wr      (sram_wr[g]),
      .sram_size    (sram_size[g]),
      .sram_wstrb   (sram_wstrb[g]),
      .sram_addr    (sram_addr[g]),
      .sram_wdata   (sram_wdata[g]),
      .sram_addr_ok (sram_addr_ok),
      .sram_data_ok (sram_data_ok),
      .sram_rdata   (sram_rdata)
    );
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of owners (oldest at index 0), lock flag/owner, last accepted master.
  int cnt[2]     = '{0, 0};
  bit ownl[2][MAXO];
  bit lk[2]      = '{0, 0};
  bit lko[2]     = '{0, 0};
  bit rrl[2]     = '{1, 1};

  task automatic model_cycle(input int m);
    bit g, req_g, e_req, pop, push, is_full;
    if (!resetn) begin
      cnt[m] = 0;
      lk[m]  = 1'b0;
      rrl[m] = 1'b1;
    end
    is_full = (cnt[m] == MAXO);
    if (lk[m])                              g = lko[m];
    else if (m == 1 && inst_req && data_req) g = !rrl[m];
    else                                     g = data_req;
    req_g = g ? data_req : inst_req;
    e_req = req_g && !is_full;
    pop   = sram_data_ok && (cnt[m] > 0);
    push  = e_req && sram_addr_ok;
    chk($sformatf("m%0d sram_req", m),   sram_req[m],   e_req);
    chk($sformatf("m%0d sram_wr", m),    sram_wr[m],    g ? data_wr : inst_wr);
    chk($sformatf("m%0d sram_size", m),  sram_size[m],  g ? data_size : inst_size);
    chk($sformatf("m%0d sram_wstrb", m), sram_wstrb[m], g ? data_wstrb : inst_wstrb);
    chk($sformatf("m%0d sram_addr", m),  sram_addr[m],  g ? data_addr : inst_addr);
    chk($sformatf("m%0d sram_wdata", m), sram_wdata[m], g ? data_wdata : inst_wdata);
    chk($sformatf("m%0d inst_addr_ok", m), inst_addr_ok[m], push && !g);
    chk($sformatf("m%0d data_addr_ok", m), data_addr_ok[m], push && g);
    chk($sformatf("m%0d inst_data_ok", m), inst_data_ok[m], pop && !ownl[m][0]);
    chk($sformatf("m%0d data_data_ok", m), data_data_ok[m], pop && ownl[m][0]);
    chk($sformatf("m%0d inst_rdata", m), inst_rdata[m], sram_rdata);
    chk($sformatf("m%0d data_rdata", m), data_rdata[m], sram_rdata);
    if (resetn) begin
      if (pop) begin
        for (int i = 0; i < MAXO - 1; i++) ownl[m][i] = ownl[m][i+1];
        cnt[m]--;
      end
      if (push) begin
        ownl[m][cnt[m]] = g;
        cnt[m]++;
        rrl[m] = g;
      end
      if (lk[m]) begin
        if (sram_addr_ok || !req_g) lk[m] = 1'b0;
      end else if (e_req && !sram_addr_ok) begin
        lk[m]  = 1'b1;
        lko[m] = g;
      end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  // One cycle of directed stimulus: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input bit ir, input bit dr, input bit aok, input bit dok, input logic [31:0] rd);
    @(posedge clk);
    #1;
    inst_req = ir;  data_req = dr;
    sram_addr_ok = aok; sram_data_ok = dok; sram_rdata = rd;
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = 32'hBFC0_0000; inst_wdata = 32'h1111_1111;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h0000_1000; data_wdata = 32'h2222_2222;
    sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 32'h0;
    #2;
    chk("reset sram_req", sram_req, 2'b00);
    chk("reset addr_ok", {inst_addr_ok, data_addr_ok}, 4'h0);
    chk("reset data_ok", {inst_data_ok, data_data_ok}, 4'h0);
    @(posedge clk); #1; resetn = 1'b1;

    // Simultaneous requests, fixed priority: data first, then inst; responses in order.
    cyc(1, 1, 1, 0, 32'h0);
    chk("t1 data first", data_addr_ok[0], 1'b1);
    chk("t1 addr data", sram_addr[0], 32'h0000_1000);
    chk("t1 rr inst first", inst_addr_ok[1], 1'b1);
    cyc(1, 0, 1, 0, 32'h0);
    chk("t1 inst second", inst_addr_ok[0], 1'b1);
    cyc(0, 0, 0, 1, 32'hAAAA_0001);
    chk("t1 data resp", data_data_ok[0], 1'b1);
    chk("t1 data rdata", data_rdata[0], 32'hAAAA_0001);
    cyc(0, 0, 0, 1, 32'hAAAA_0002);
    chk("t1 inst resp", inst_data_ok[0], 1'b1);
    chk("t1 inst rdata", inst_rdata[0], 32'hAAAA_0002);

    // Lock under stall: inst keeps the port while data waits.
    cyc(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0, 32'h0);
      chk("lock addr held", sram_addr[0], 32'hBFC0_0000);
      chk("lock no data grant", data_addr_ok[0], 1'b0);
    end
    cyc(1, 1, 1, 0, 32'h0);
    chk("lock inst accepted", inst_addr_ok[0], 1'b1);
    cyc(0, 1, 1, 0, 32'h0);
    chk("lock data after", data_addr_ok[0], 1'b1);
    cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 1, 32'h0);

    // Full: four inst reads outstanding block the fifth until a pop has registered.
    for (int i = 0; i < MAXO; i++) begin
      cyc(1, 0, 1, 0, 32'h0);
      chk("full fill", inst_addr_ok[0], 1'b1);
    end
    cyc(1, 0, 1, 0, 32'h0);
    chk("full blocks", sram_req[0], 1'b0);
    cyc(1, 0, 1, 1, 32'h5);
    chk("full pop same cycle", sram_req[0], 1'b0);
    chk("full pop resp", inst_data_ok[0], 1'b1);
    cyc(1, 0, 1, 0, 32'h0);
    chk("full resumes", sram_req[0], 1'b1);
    for (int i = 0; i < MAXO; i++) cyc(0, 0, 0, 1, 32'h0);

    // Round-robin: after reset grants alternate starting with inst.
    @(posedge clk); #1; resetn = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      cyc(1, 1, 1, 0, 32'h0);
      chk("rr data grant", data_addr_ok[1], (i % 2) == 1);
      chk("rr inst grant", inst_addr_ok[1], (i % 2) == 0);
    end
    for (int i = 0; i < MAXO; i++) cyc(0, 0, 0, 1, 32'h0);

    // Cancel while locked, then a stray response with nothing outstanding.
    data_addr = 32'h0000_2000;
    cyc(0, 1, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    chk("cancel locked to data", sram_req[0], 1'b0);
    cyc(1, 0, 1, 0, 32'h0);
    chk("cancel inst accepted", inst_addr_ok[0], 1'b1);
    cyc(0, 0, 0, 1, 32'h7);
    chk("cancel only inst", inst_data_ok[0], 1'b1);
    cyc(0, 0, 0, 1, 32'h8);
    chk("stray dropped", {inst_data_ok[0], data_data_ok[0]}, 2'b00);

    // Reset mid-operation with transactions outstanding and a lock pending.
    cyc(1, 1, 1, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    data_req = 1'b1;
    resetn = 1'b0;
    #1;
    chk("rst lock cleared fixed", sram_addr[0], 32'h0000_2000);
    chk("rst lock cleared rr", sram_addr[1], 32'hBFC0_0000);
    @(negedge clk);
    @(posedge clk); #1; resetn = 1'b1;
    cyc(0, 0, 0, 1, 32'h9);
    chk("rst resp dropped", {inst_data_ok, data_data_ok}, 4'h0);
    cyc(0, 0, 0, 1, 32'hA);
    chk("rst resp dropped 2", {inst_data_ok, data_data_ok}, 4'h0);

    // Randomized traffic: masters mostly hold requests, slave stalls and responds at random.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      resetn = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) == 0) begin
        inst_req   = ($urandom_range(0, 3) != 0);
        inst_wr    = $urandom_range(0, 1);
        inst_size  = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom);
        inst_addr  = $urandom;
        inst_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        data_req   = ($urandom_range(0, 3) != 0);
        data_wr    = $urandom_range(0, 1);
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      sram_addr_ok = $urandom_range(0, 1);
      sram_data_ok = ($urandom_range(0, 4) < 2);
      sram_rdata   = $urandom;
    end
    @(negedge clk);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
